mont_exp_ctrl: RTL
==================

Name: mont_exp_ctrl

Overview:
- Modular exponentiation sequencer directly upstream of the Montgomery multiplier core.
- Latches a message, exponent and modulus, then issues a chain of Montgomery multiplications over a start/done handshake:
  - domain entry
  - left-to-right square-and-multiply
  - domain exit
- Returns x^e mod M. It is the RSA encrypt/decrypt engine wrapped around the multiplier.
- The multiplier is external: the caller wires mul_* ports to a montgomery instance.

Parameters:
- WIDTH, 1024, operand/modulus width in bits; Montgomery R = 2^WIDTH
- ELEN_W, 11, width of exponent-length field; must be >= clog2(WIDTH+1)

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- in_x  in  WIDTH  message, < M
- in_e  in  WIDTH  exponent
- in_e_len  in  ELEN_W  number of exponent bits to process (0..WIDTH), MSB at index in_e_len-1
- in_m  in  WIDTH  odd modulus
- in_r  in  WIDTH  R mod M
- in_r2  in  WIDTH  R^2 mod M
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse, result valid from that cycle
- result  out  WIDTH  x^e mod M; held until next accepted start
- mul_start  out  1  one-cycle pulse to multiplier
- mul_a  out  WIDTH  multiplier operand A
- mul_b  out  WIDTH  multiplier operand B
- mul_m  out  WIDTH  latched modulus
- mul_result  in  WIDTH  multiplier output = a*b*R^-1 mod M
- mul_done  in  1  one-cycle pulse, mul_result valid same cycle

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE
  - busy, done, mul_start = 0
  - result, mul_a, mul_b, mul_m, internal regs = 0
- Reset mid-operation aborts immediately. No further mul_start is issued; a late mul_done arriving in IDLE is ignored.
- IDLE:
  - On start=1, latch in_x, in_e, in_m, in_r, in_r2, and set bit index i = in_e_len.
  - Next cycle: busy=1, go to PRE.
  - start while busy is ignored.
- Every multiply step uses two substates, ISSUE and WAIT:
  - ISSUE drives mul_a/mul_b and pulses mul_start for exactly one cycle, then moves to WAIT.
  - mul_a, mul_b and mul_m are held stable from ISSUE until mul_done.
  - In WAIT, mul_done=1 captures mul_result in the same edge and advances.
- Sequence, with acc = accumulator and xt = message in Montgomery form:
  - PRE: xt = MM(x, r2); acc = r. If i==0, go to POST.
  - SQ: acc = MM(acc, acc); then i = i-1. If e[i] (the new i) = 1, go to MUL; else if i==0, go to POST; else SQ.
  - MUL: acc = MM(acc, xt). If i==0, go to POST; else SQ.
  - POST: acc = MM(acc, 1). Then result = acc, done=1 for one cycle, busy=0, return to IDLE.
- Multiplication count = 2 + in_e_len + popcount(in_e[in_e_len-1:0]). Bits of in_e at index >= in_e_len are ignored.
- in_e_len > WIDTH is clamped to WIDTH.
- Latency = sum of multiplier latencies + 2 cycles per multiply + 2. Total is fixed for a given multiplier latency; it does not depend on result values.
- done and the return to IDLE occur on the same edge. A new start is accepted on the next cycle.

Decomposition:
- Shared package holds:
  - state enum: IDLE, PRE_I, PRE_W, SQ_I, SQ_W, MUL_I, MUL_W, POST_I, POST_W, DONE
  - default WIDTH and ELEN_W
  - localparam ONE = {{WIDTH-1{1'b0}},1'b1}
- One flat module; no sub-module is needed.
- Bench pairs it with a behavioural Montgomery model with programmable latency, and separately with montgomery_v2 at WIDTH=1024.

Test Plan:
- WIDTH=8, M=13, r=9, r2=3, x=2, e=5, e_len=3, model latency 4 -> result=6, exactly 7 mul_start pulses, done one cycle, busy low after.
- Same setup, e=0, e_len=0 -> result=1, exactly 2 mul_start pulses.
- WIDTH=8, M=13, x=7, e=0xFF, e_len=8 -> result=7^255 mod 13=5, 18 mul_start pulses; start pulsed mid-run is ignored and result stays unchanged.
- Reset mid-run:
  - assert resetn=0 during SQ_W, then inject a late mul_done -> all outputs 0, state IDLE, no mul_start.
  - next start with x=2, e=5 -> result=6.
- Handshake checks:
  - mul_a/mul_b stable for every cycle between mul_start and mul_done, with model latencies 1 and 37.
  - in_e_len=3 with in_e=0xFD -> result 6 (upper bits ignored).
- WIDTH=1024 with montgomery_v2 and a known RSA vector (x, e=65537, e_len=17) -> result matches golden model.

Source files
------------

// File: rtl/mont_exp_ctrl_pkg.sv
// mont_exp_ctrl_pkg: shared state encoding and default sizes for the
// Montgomery modular-exponentiation sequencer.
package mont_exp_ctrl_pkg;
    localparam int DEF_WIDTH  = 1024;
    localparam int DEF_ELEN_W = 11;

    typedef enum logic [3:0] {
        IDLE, PRE_I, PRE_W, SQ_I, SQ_W, MUL_I, MUL_W, POST_I, POST_W, DONE
    } state_t;
endpackage

// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl: left-to-right square-and-multiply sequencer driving an
// external Montgomery multiplier over a start/done handshake.
module mont_exp_ctrl
    import mont_exp_ctrl_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ELEN_W = DEF_ELEN_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [WIDTH-1:0]  in_x,
    input  logic [WIDTH-1:0]  in_e,
    input  logic [ELEN_W-1:0] in_e_len,
    input  logic [WIDTH-1:0]  in_m,
    input  logic [WIDTH-1:0]  in_r,
    input  logic [WIDTH-1:0]  in_r2,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic              mul_start,
    output logic [WIDTH-1:0]  mul_a,
    output logic [WIDTH-1:0]  mul_b,
    output logic [WIDTH-1:0]  mul_m,
    input  logic [WIDTH-1:0]  mul_result,
    input  logic              mul_done
);
    localparam logic [WIDTH-1:0]  ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ELEN_W-1:0] ELMAX = ELEN_W'(WIDTH);

    state_t            r_state, w_next;
    logic [ELEN_W-1:0] r_i, w_i_dec, w_elen;
    logic [WIDTH-1:0]  r_x, r_e, r_m, r_r2, r_acc, r_xt, r_result, r_mul_a, r_mul_b, w_e_sh;
    logic              r_busy, r_done, r_mul_start, w_e_bit;

    assign w_i_dec   = r_i - ELEN_W'(1);
    assign w_e_sh    = r_e >> w_i_dec;
    assign w_e_bit   = w_e_sh[0];
    assign w_elen    = (in_e_len > ELMAX) ? ELMAX : in_e_len;
    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign mul_start = r_mul_start;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign mul_m     = r_m;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? PRE_I : IDLE;
            PRE_I:   w_next = PRE_W;
            SQ_I:    w_next = SQ_W;
            MUL_I:   w_next = MUL_W;
            POST_I:  w_next = POST_W;
            PRE_W:   if (mul_done) w_next = (r_i == '0) ? POST_I : SQ_I;
            SQ_W:    if (mul_done) w_next = w_e_bit ? MUL_I : ((w_i_dec == '0) ? POST_I : SQ_I);
            MUL_W:   if (mul_done) w_next = (r_i == '0) ? POST_I : SQ_I;
            POST_W:  if (mul_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operands are loaded on the ISSUE edge and held until the WAIT state sees mul_done.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x <= '0; r_e <= '0; r_m <= '0; r_r2 <= '0; r_acc <= '0; r_xt <= '0;
            r_i <= '0; r_result <= '0; r_mul_a <= '0; r_mul_b <= '0;
            r_busy <= 1'b0; r_done <= 1'b0; r_mul_start <= 1'b0;
        end else begin
            r_mul_start <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_x <= in_x; r_e <= in_e; r_m <= in_m; r_r2 <= in_r2;
                    r_acc <= in_r; r_i <= w_elen; r_busy <= 1'b1;
                end
                PRE_I:  begin r_mul_a <= r_x;   r_mul_b <= r_r2;  r_mul_start <= 1'b1; end
                SQ_I:   begin r_mul_a <= r_acc; r_mul_b <= r_acc; r_mul_start <= 1'b1; end
                MUL_I:  begin r_mul_a <= r_acc; r_mul_b <= r_xt;  r_mul_start <= 1'b1; end
                POST_I: begin r_mul_a <= r_acc; r_mul_b <= ONE;   r_mul_start <= 1'b1; end
                PRE_W:  if (mul_done) r_xt <= mul_result;
                SQ_W:   if (mul_done) begin r_acc <= mul_result; r_i <= w_i_dec; end
                MUL_W:  if (mul_done) r_acc <= mul_result;
                POST_W: if (mul_done) begin r_result <= mul_result; r_done <= 1'b1; r_busy <= 1'b0; end
                default: ;
            endcase
        end
    end
endmodule
